mc6809_bus_responder: RTL and testbench

MC6809_BUS_RESPONDER -- requirements
Module: mc6809_bus_responder

---
 rtl/mc6809_bus_responder.sv | 194 +++++++++++++++++++
 tb/tb_mc6809_bus_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mc6809_bus_responder.sv
// MC6809 bus-cycle responder: RAM, scratch register, I/O stretch region,
// vector fetch and unmapped fill, sequenced from the CPU's E/Q phase clocks.
module mc6809_bus_responder #(
    parameter logic [7:0]  FILL_BYTE    = 8'h12,
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned WAIT_STATES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ADDR,
    input  logic [7:0]  DOut,
    input  logic        RnW,
    input  logic        E,
    input  logic        Q,
    input  logic        BS,
    input  logic        BA,
    output logic [7:0]  D,
    output logic        MRDY,
    output logic [31:0] cycle_count,
    output logic        vector_fetch
);

    localparam int unsigned WAIT_W    = 4;
    localparam bit          STRETCH_EN = (WAIT_STATES != 0);
    // Counter counts down to zero, so a stretch of N clks loads N-1.
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        STRETCH_EN ? WAIT_W'(WAIT_STATES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_STRETCH,
        S_DATA
    } state_t;

    state_t              r_state;
    logic                r_q_d;
    logic                r_e_d;
    logic [15:0]         r_addr;
    logic                r_rnw;
    logic                r_bs;
    logic [7:0]          r_d;
    logic                r_mrdy;
    logic                r_vf;
    logic [31:0]         r_count;
    logic [WAIT_W-1:0]   r_wait;
    logic [7:0]          r_scratch;
    logic [7:0]          r_ram [256];

    state_t              w_state_nxt;
    logic [7:0]          w_d_nxt;
    logic                w_mrdy_nxt;
    logic                w_vf_nxt;
    logic [31:0]         w_count_nxt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [7:0]          w_scratch_nxt;
    logic                w_ram_we;

    logic                w_q_rise;
    logic                w_e_fall;
    logic [15:0]         w_addr;
    logic                w_rnw;
    logic                w_bs;
    logic                w_is_ram;
    logic                w_is_scr;
    logic                w_is_io;
    logic                w_is_vec;
    logic [7:0]          w_rd_data;

    assign w_q_rise = Q & ~r_q_d;
    assign w_e_fall = ~E & r_e_d;

    // In DECODE the live bus is what gets latched; afterwards only latched values count.
    assign w_addr = (r_state == S_DECODE) ? ADDR : r_addr;
    assign w_rnw  = (r_state == S_DECODE) ? RnW  : r_rnw;
    assign w_bs   = (r_state == S_DECODE) ? BS   : r_bs;

    assign w_is_ram = (w_addr[15:8] == 8'h00);
    assign w_is_scr = (w_addr == 16'hE000);
    assign w_is_io  = (w_addr[15:8] == 8'hE0);
    assign w_is_vec = (w_addr[15:4] == 12'hFFF) && w_bs;

    // Read-data mux over the decoded regions.
    always_comb begin
        w_rd_data = FILL_BYTE;
        if (w_is_ram) begin
            w_rd_data = r_ram[w_addr[7:0]];
        end else if (w_is_scr) begin
            w_rd_data = r_scratch;
        end else if (w_is_io) begin
            w_rd_data = 8'h00;
        end else if (w_is_vec) begin
            if (w_addr == 16'hFFFE)      w_rd_data = RESET_VECTOR[15:8];
            else if (w_addr == 16'hFFFF) w_rd_data = RESET_VECTOR[7:0];
            else                         w_rd_data = 8'h00;
        end
    end

    // Next-state and next-output logic for the bus-cycle sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_d_nxt       = r_d;
        w_mrdy_nxt    = r_mrdy;
        w_vf_nxt      = 1'b0;
        w_count_nxt   = r_count;
        w_wait_nxt    = r_wait;
        w_scratch_nxt = r_scratch;
        w_ram_we      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_mrdy_nxt = 1'b1;
                if (w_q_rise && !BA) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_io && STRETCH_EN) begin
                    w_state_nxt = S_STRETCH;
                    w_mrdy_nxt  = 1'b0;
                    w_wait_nxt  = WAIT_LOAD;
                end else begin
                    w_state_nxt = S_DATA;
                    w_mrdy_nxt  = 1'b1;
                    if (w_rnw) w_d_nxt = w_rd_data;
                    w_vf_nxt    = w_rnw && w_is_vec;
                end
            end
            S_STRETCH: begin
                if (r_wait == '0) begin
                    w_state_nxt = S_DATA;
                    w_mrdy_nxt  = 1'b1;
                    if (w_rnw) w_d_nxt = w_rd_data;
                    w_vf_nxt    = w_rnw && w_is_vec;
                end else begin
                    w_wait_nxt  = r_wait - WAIT_W'(1);
                end
            end
            S_DATA: begin
                if (w_e_fall) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = r_count + 32'd1;
                    if (!w_rnw) begin
                        if (w_is_ram)      w_ram_we      = 1'b1;
                        else if (w_is_scr) w_scratch_nxt = DOut;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any cycle in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_q_d     <= 1'b0;
            r_e_d     <= 1'b0;
            r_addr    <= 16'h0000;
            r_rnw     <= 1'b1;
            r_bs      <= 1'b0;
            r_d       <= FILL_BYTE;
            r_mrdy    <= 1'b1;
            r_vf      <= 1'b0;
            r_count   <= 32'd0;
            r_wait    <= '0;
            r_scratch <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_q_d     <= Q;
            r_e_d     <= E;
            r_d       <= w_d_nxt;
            r_mrdy    <= w_mrdy_nxt;
            r_vf      <= w_vf_nxt;
            r_count   <= w_count_nxt;
            r_wait    <= w_wait_nxt;
            r_scratch <= w_scratch_nxt;
            if (r_state == S_DECODE) begin
                r_addr <= ADDR;
                r_rnw  <= RnW;
                r_bs   <= BS;
            end
        end
    end

    // RAM array; contents survive reset, but a write is dropped if reset lands on it.
    always_ff @(posedge clk) begin
        if (!reset && w_ram_we) r_ram[r_addr[7:0]] <= DOut;
    end

    assign D            = r_d;
    assign MRDY         = r_mrdy;
    assign cycle_count  = r_count;
    assign vector_fetch = r_vf;

endmodule

// File: tb/tb_mc6809_bus_responder.sv
// Directed bench for mc6809_bus_responder: E/Q bus cycles with hand-computed expectations.
module tb_mc6809_bus_responder;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rnw;
    logic        e;
    logic        q;
    logic        bs;
    logic        ba;
    logic [7:0]  d;
    logic        mrdy;
    logic [31:0] cycle_count;
    logic        vector_fetch;

    int n_checks = 0;
    int n_errors = 0;

    mc6809_bus_responder #(
        .FILL_BYTE    (8'h12),
        .RESET_VECTOR (16'hC000),
        .WAIT_STATES  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ADDR         (addr),
        .DOut         (dout),
        .RnW          (rnw),
        .E            (e),
        .Q            (q),
        .BS           (bs),
        .BA           (ba),
        .D            (d),
        .MRDY         (mrdy),
        .cycle_count  (cycle_count),
        .vector_fetch (vector_fetch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full bus cycle, 4 clks per quarter; counts MRDY-low clks and vector pulses.
    task automatic run_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                             input logic b, output logic [7:0] rd, output int lo, output int vf);
        lo   = 0;
        vf   = 0;
        rd   = 8'h00;
        addr = a;
        rnw  = rw;
        dout = wd;
        bs   = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mrdy) lo++;
            if (vector_fetch) vf++;
            case (i)
                4:  q = 1'b1;
                8:  e = 1'b1;
                12: q = 1'b0;
                16: begin rd = d; e = 1'b0; end
                default: ;
            endcase
        end
    endtask

    logic [7:0]  rd;
    int          lo;
    int          vf;
    int          lo_sum;
    int          vf_sum;
    logic [7:0]  d_hold;
    logic [31:0] cnt_hold;

    initial begin
        reset = 1'b1;
        addr  = 16'h0000;
        dout  = 8'h00;
        rnw   = 1'b1;
        e     = 1'b0;
        q     = 1'b0;
        bs    = 1'b0;
        ba    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_d", 32'(d), 32'h12);
        chk("reset_mrdy", 32'(mrdy), 32'd1);
        chk("reset_count", cycle_count, 32'd0);
        chk("reset_vf", 32'(vector_fetch), 32'd0);
        reset = 1'b0;

        // Free-running reads of low RAM, then an unmapped read.
        lo_sum = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(16'(i), 1'b1, 8'h00, 1'b0, rd, lo, vf);
            lo_sum += lo;
        end
        chk("freerun_count", cycle_count, 32'd10);
        chk("freerun_mrdy_low", 32'(lo_sum), 32'd0);
        run_cycle(16'h1234, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("unmapped_1234", 32'(rd), 32'h12);

        // Vector fetches with BS=1, then the same addresses as dead cycles.
        run_cycle(16'hFFFE, 1'b1, 8'h00, 1'b1, rd, lo, vf);
        chk("vec_fffe_d", 32'(rd), 32'hC0);
        chk("vec_fffe_pulse", 32'(vf), 32'd1);
        run_cycle(16'hFFFF, 1'b1, 8'h00, 1'b1, rd, lo, vf);
        chk("vec_ffff_d", 32'(rd), 32'h00);
        chk("vec_ffff_pulse", 32'(vf), 32'd1);
        run_cycle(16'hFFFE, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("dead_fffe_d", 32'(rd), 32'h12);
        chk("dead_fffe_pulse", 32'(vf), 32'd0);
        run_cycle(16'hFFFF, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("dead_ffff_d", 32'(rd), 32'h12);
        chk("dead_ffff_pulse", 32'(vf), 32'd0);
        run_cycle(16'hFFF4, 1'b1, 8'h00, 1'b1, rd, lo, vf);
        chk("vec_fff4_d", 32'(rd), 32'h00);

        // RAM write/read-back and a discarded unmapped write.
        run_cycle(16'h0042, 1'b0, 8'hA5, 1'b0, rd, lo, vf);
        run_cycle(16'h0042, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("ram_0042", 32'(rd), 32'hA5);
        run_cycle(16'h0043, 1'b0, 8'h3C, 1'b0, rd, lo, vf);
        run_cycle(16'h0043, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("ram_0043", 32'(rd), 32'h3C);
        run_cycle(16'h2000, 1'b0, 8'h5A, 1'b0, rd, lo, vf);
        run_cycle(16'h2000, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("unmapped_2000", 32'(rd), 32'h12);

        // Bus granted for 5 E periods: nothing is serviced.
        d_hold   = d;
        cnt_hold = cycle_count;
        ba       = 1'b1;
        lo_sum   = 0;
        vf_sum   = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(16'h0042, 1'b1, 8'h00, 1'b1, rd, lo, vf);
            lo_sum += lo;
            vf_sum += vf;
        end
        chk("grant_d_hold", 32'(d), 32'(d_hold));
        chk("grant_mrdy_low", 32'(lo_sum), 32'd0);
        chk("grant_count", cycle_count, cnt_hold);
        chk("grant_vf", 32'(vf_sum), 32'd0);
        ba = 1'b0;
        run_cycle(16'h0042, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("resume_count", cycle_count, cnt_hold + 32'd1);
        chk("resume_d", 32'(rd), 32'hA5);

        // I/O region stretch.
        run_cycle(16'hE000, 1'b0, 8'h77, 1'b0, rd, lo, vf);
        chk("io_wr_mrdy_low", 32'(lo), 32'd2);
        run_cycle(16'hE000, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("io_rd_mrdy_low", 32'(lo), 32'd2);
        chk("scratch_rd", 32'(rd), 32'h77);
        run_cycle(16'hE010, 1'b0, 8'hFF, 1'b0, rd, lo, vf);
        run_cycle(16'hE010, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("io_e010_d", 32'(rd), 32'h00);
        chk("io_e010_mrdy_low", 32'(lo), 32'd2);

        // Reset on the first STRETCH clk of a scratch write.
        addr = 16'hE000;
        rnw  = 1'b0;
        dout = 8'h33;
        bs   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            case (i)
                4: q = 1'b1;
                6: begin
                    chk("stretch_entry_mrdy", 32'(mrdy), 32'd0);
                    reset = 1'b1;
                end
                7: begin
                    chk("abort_mrdy", 32'(mrdy), 32'd1);
                    chk("abort_count", cycle_count, 32'd0);
                    chk("abort_d", 32'(d), 32'h12);
                    reset = 1'b0;
                    q     = 1'b0;
                end
                default: ;
            endcase
        end
        repeat (4) @(negedge clk);
        chk("post_abort_count", cycle_count, 32'd0);
        run_cycle(16'hE000, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("post_abort_scratch", 32'(rd), 32'h00);
        chk("post_abort_count1", cycle_count, 32'd1);
        run_cycle(16'h0042, 1'b1, 8'h00, 1'b0, rd, lo, vf);
        chk("ram_survives_reset", 32'(rd), 32'hA5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
